// File: rtl/sram_requester_if.sv
// Mux-port bus between one burst requester and the SRAM port mux.
// The requester drives req/addr/wdata and the single-cycle rd/wr strobes.
// The mux/controller side returns rdata with a one-cycle valid pulse, plus busy.
//   master : requester side (drives req, addr, wdata, wr, rd)
//   slave  : mux side (drives rdata, valid, busy)
interface sram_requester_if;
    logic        req;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic        rd;
    logic [15:0] rdata;
    logic        valid;
    logic        busy;

    modport master (
        output req, addr, wdata, wr, rd,
        input  rdata, valid, busy
    );

    modport slave (
        input  req, addr, wdata, wr, rd,
        output rdata, valid, busy
    );
endinterface

// File: rtl/sram_requester.sv
// Burst requester for one port of the SRAM port mux.
// A burst command (start address, length, direction) is turned into one
// rd/wr strobe per word on the mux port. req is held for the whole burst.
// Write words are taken from the wd_* stream. Read words land in a small
// show-ahead FIFO that the client drains through rd_*.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only while idle)
//   cmd_write/cmd_addr/cmd_len   direction, first address, length (0 = 256)
//   wd_valid/wd_data/wd_ready    write-data stream (wd_ready = word consumed)
//   rd_valid/rd_data/rd_ready    read-data FIFO head and pop
//   done                         one-cycle pulse when the last word completes
//   mux                          mux-port bus (master side)
module sram_requester #(
    parameter int BLIND_CYCLES = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [15:0]      cmd_addr,
    input  logic [7:0]       cmd_len,
    input  logic             wd_valid,
    input  logic [15:0]      wd_data,
    output logic             wd_ready,
    output logic             rd_valid,
    output logic [15:0]      rd_data,
    input  logic             rd_ready,
    output logic             done,
    sram_requester_if.master mux
);

    // FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally.
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int BLIND_W = (BLIND_CYCLES > 1) ? $clog2(BLIND_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BLIND = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t              state_reg;
    logic                cmd_ready_reg;
    logic                req_reg;
    logic                write_reg;
    logic [15:0]         addr_reg;
    logic [15:0]         wdata_reg;
    logic [8:0]          remaining_reg;
    logic [BLIND_W-1:0]  blind_reg;
    logic                got_valid_reg;

    logic [15:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    logic pop;
    logic push;
    logic space_ok;
    logic issue;
    logic wr_strobe;
    logic rd_strobe;
    logic word_done;
    logic last_word;

    // ------------------------------------------------------------------
    // Strobe / completion decode. These are Mealy terms: a strobe fires in
    // the same ISSUE cycle that busy drops (or write data shows up), and
    // done fires in the WAIT cycle that completes the last word.
    // ------------------------------------------------------------------
    always_comb begin
        pop       = rd_ready && (count_reg != '0);
        // A pop in the same cycle frees the slot the new read will need.
        space_ok  = (count_reg != CNT_W'(FIFO_DEPTH)) || pop;
        issue     = (state_reg == ISSUE) && !mux.busy &&
                    (write_reg ? wd_valid : space_ok);
        wr_strobe = issue && write_reg;
        rd_strobe = issue && !write_reg;
        // Read data is only accepted while a read word is outstanding.
        push      = mux.valid && !write_reg &&
                    ((state_reg == BLIND) || (state_reg == WAIT));
        word_done = (state_reg == WAIT) && !mux.busy &&
                    (write_reg || got_valid_reg || mux.valid);
        last_word = (remaining_reg == 9'd1);
    end

    assign cmd_ready = cmd_ready_reg;
    assign wd_ready  = wr_strobe;
    assign done      = word_done && last_word;
    assign rd_valid  = (count_reg != '0);
    // Empty FIFO presents zero rather than stale storage.
    assign rd_data   = rd_valid ? fifo_mem[rd_ptr_reg] : 16'h0000;

    assign mux.req   = req_reg;
    assign mux.addr  = addr_reg;
    assign mux.wr    = wr_strobe;
    assign mux.rd    = rd_strobe;
    // wdata shows the new word during its strobe and then holds it.
    assign mux.wdata = wr_strobe ? wd_data : wdata_reg;

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            req_reg       <= 1'b0;
            write_reg     <= 1'b0;
            addr_reg      <= 16'h0000;
            wdata_reg     <= 16'h0000;
            remaining_reg <= 9'd0;
            blind_reg     <= '0;
            got_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                got_valid_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (cmd_valid && cmd_ready_reg) begin
                        write_reg     <= cmd_write;
                        addr_reg      <= cmd_addr;
                        remaining_reg <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
                        req_reg       <= 1'b1;
                        cmd_ready_reg <= 1'b0;
                        state_reg     <= ISSUE;
                    end else begin
                        // Also raises cmd_ready on the first edge after reset.
                        cmd_ready_reg <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (issue) begin
                        if (write_reg) begin
                            wdata_reg <= wd_data;
                        end
                        got_valid_reg <= 1'b0;
                        blind_reg     <= BLIND_W'(BLIND_CYCLES);
                        state_reg     <= (BLIND_CYCLES == 0) ? WAIT : BLIND;
                    end
                end

                BLIND: begin
                    // busy from before the mux saw this strobe is stale here.
                    blind_reg <= blind_reg - 1'b1;
                    if (blind_reg <= BLIND_W'(1)) begin
                        state_reg <= WAIT;
                    end
                end

                WAIT: begin
                    if (word_done) begin
                        if (last_word) begin
                            req_reg       <= 1'b0;
                            cmd_ready_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end else begin
                            addr_reg      <= addr_reg + 16'd1;
                            remaining_reg <= remaining_reg - 9'd1;
                            state_reg     <= ISSUE;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-data FIFO. The ISSUE space check guarantees push never
    // overflows; pop on empty is masked in the pop term.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= mux.rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_requester.sv
// Directed bench for sram_requester with a small controller model:
// busy rises the cycle after a strobe for busy_len cycles; a read returns
// either a fixed word or its own address valid_delay cycles after the strobe.
module tb_sram_requester;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = 16'h0000;
    logic [7:0]  cmd_len = 8'd0;
    logic        wd_valid = 1'b0;
    logic [15:0] wd_data = 16'h0000;
    logic        wd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_ready = 1'b0;
    logic        done;

    sram_requester_if bus();

    sram_requester #(.BLIND_CYCLES(2), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wd_valid  (wd_valid),
        .wd_data   (wd_data),
        .wd_ready  (wd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .done      (done),
        .mux       (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int errors = 0;

    // ---------------- monitor (mid-cycle sampling) ----------------
    int cyc = 0;
    int wr_count = 0, rd_count = 0, wd_ready_count = 0, done_count = 0;
    int strobe_no_wd = 0, both_high = 0, strobe_busy = 0;
    int done_cyc = 0, valid_cyc = 0, rdv_rise_cyc = 0;
    bit rdv_prev = 1'b0;
    logic [15:0] addr_log[$];
    logic [15:0] wdata_log[$];
    int strobe_cyc[$];
    bit saw_strobe = 1'b0, saw_rd = 1'b0;
    logic [15:0] saw_addr = 16'h0000;

    always @(negedge clk) begin
        cyc++;
        saw_strobe = bus.wr | bus.rd;
        saw_rd     = bus.rd;
        saw_addr   = bus.addr;
        if (bus.wr) begin
            wr_count++;
            addr_log.push_back(bus.addr);
            wdata_log.push_back(bus.wdata);
            strobe_cyc.push_back(cyc);
            if (!wd_valid) strobe_no_wd++;
        end
        if (bus.rd) begin
            rd_count++;
            addr_log.push_back(bus.addr);
            strobe_cyc.push_back(cyc);
        end
        if (bus.wr && bus.rd) both_high++;
        if ((bus.wr || bus.rd) && bus.busy) strobe_busy++;
        if (wd_ready) wd_ready_count++;
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (bus.valid) valid_cyc = cyc;
        if (rd_valid && !rdv_prev) rdv_rise_cyc = cyc;
        rdv_prev = rd_valid;
    end

    // ---------------- controller model ----------------
    int busy_len = 3;
    int valid_delay = 2;
    bit ret_fixed_en = 1'b0;
    logic [15:0] ret_fixed = 16'h0000;
    int busy_cnt = 0, valid_cnt = 0;
    logic [15:0] pend_data = 16'h0000;

    initial begin
        bus.busy  = 1'b0;
        bus.valid = 1'b0;
        bus.rdata = 16'h0000;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            bus.busy  = 1'b0;
            bus.valid = 1'b0;
            busy_cnt  = 0;
            valid_cnt = 0;
        end else begin
            bus.valid = 1'b0;
            if (saw_strobe) begin
                busy_cnt = busy_len;
                if (saw_rd) begin
                    valid_cnt = valid_delay;
                    pend_data = ret_fixed_en ? ret_fixed : saw_addr;
                end
            end
            if (busy_cnt > 0) begin
                bus.busy = 1'b1;
                busy_cnt--;
            end else begin
                bus.busy = 1'b0;
            end
            if (valid_cnt > 0) begin
                valid_cnt--;
                if (valid_cnt == 0) begin
                    bus.valid = 1'b1;
                    bus.rdata = pend_data;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_count = 0; rd_count = 0; wd_ready_count = 0; done_count = 0;
        strobe_no_wd = 0;
        addr_log.delete();
        wdata_log.delete();
        strobe_cyc.delete();
    endtask

    task automatic send_cmd(input bit write, input logic [15:0] a, input logic [7:0] len,
                            output int accept_cyc, output bit ok);
        ok = 1'b0;
        accept_cyc = 0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            cmd_valid = 1'b1;
            cmd_write = write;
            cmd_addr  = a;
            cmd_len   = len;
            accept_cyc = cyc + 1;
            tick();
            cmd_valid = 1'b0;
            $display("[TB] cmd write=%0d addr=%h len=%0d accepted cycle %0d", write, a, len, accept_cyc);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start;
        start = done_count;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_count > start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if ({cmd_ready, bus.req, bus.wr, bus.rd, wd_ready, rd_valid, done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {cmd_ready, bus.req, bus.wr, bus.rd, wd_ready, rd_valid, done});
        end
        tests++;
        if ({bus.addr, bus.wdata, rd_data} !== 48'h0) begin
            errors++;
            $display("FAIL reset_buses: got %h expected 0", {bus.addr, bus.wdata, rd_data});
        end
        rst_n = 1'b1;
        tick();
        tick();
        tests++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_single_write();
        int acc;
        bit ok;
        clear_logs();
        wd_valid = 1'b1;
        wd_data  = 16'hBEEF;
        send_cmd(1'b1, 16'h1234, 8'd1, acc, ok);
        wait_done(40, ok);
        wd_valid = 1'b0;
        tests++;
        if (!ok) begin
            errors++;
            $display("FAIL wr1_done_timeout: got no done expected done");
        end
        tests++;
        if (wr_count !== 1 || rd_count !== 0 || wd_ready_count !== 1) begin
            errors++;
            $display("FAIL wr1_counts: got wr=%0d rd=%0d wd_ready=%0d expected 1 0 1",
                     wr_count, rd_count, wd_ready_count);
        end
        tests++;
        if (addr_log[0] !== 16'h1234 || wdata_log[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr1_bus: got addr=%h wdata=%h expected 1234 beef", addr_log[0], wdata_log[0]);
        end
        tests++;
        if (strobe_cyc[0] !== acc + 1) begin
            errors++;
            $display("FAIL wr1_strobe_latency: got cycle %0d expected %0d", strobe_cyc[0], acc + 1);
        end
        tests++;
        if (done_cyc - strobe_cyc[0] !== 4) begin
            errors++;
            $display("FAIL wr1_done_latency: got %0d expected 4", done_cyc - strobe_cyc[0]);
        end
        tests++;
        if (bus.req !== 1'b0 || cmd_ready !== 1'b1 || done_count !== 1) begin
            errors++;
            $display("FAIL wr1_after: got req=%b cmd_ready=%b done_count=%0d expected 0 1 1",
                     bus.req, cmd_ready, done_count);
        end
        $display("[TB] single write finished");
    endtask

    task automatic test_single_read();
        int acc;
        bit ok;
        clear_logs();
        ret_fixed_en = 1'b1;
        ret_fixed    = 16'hA5A5;
        rd_ready     = 1'b0;
        send_cmd(1'b0, 16'h0010, 8'd1, acc, ok);
        wait_done(40, ok);
        ret_fixed_en = 1'b0;
        tests++;
        if (!ok || done_count !== 1) begin
            errors++;
            $display("FAIL rd1_done: got done_count=%0d expected 1", done_count);
        end
        tests++;
        if (rd_count !== 1 || wr_count !== 0 || addr_log[0] !== 16'h0010) begin
            errors++;
            $display("FAIL rd1_strobe: got rd=%0d wr=%0d addr=%h expected 1 0 0010",
                     rd_count, wr_count, addr_log[0]);
        end
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL rd1_data: got valid=%b data=%h expected 1 a5a5", rd_valid, rd_data);
        end
        tests++;
        if (rdv_rise_cyc !== valid_cyc + 1) begin
            errors++;
            $display("FAIL rd1_latency: got rd_valid at %0d expected %0d", rdv_rise_cyc, valid_cyc + 1);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        tests++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd1_pop: got rd_valid=%b expected 0", rd_valid);
        end
        $display("[TB] single read finished");
    endtask

    task automatic test_read_backpressure();
        int acc;
        bit ok;
        clear_logs();
        rd_ready = 1'b0;
        send_cmd(1'b0, 16'h0100, 8'd6, acc, ok);
        repeat (40) tick();
        tests++;
        if (rd_count !== 4 || bus.req !== 1'b1 || done_count !== 0) begin
            errors++;
            $display("FAIL rdb_stall: got rd=%0d req=%b done=%0d expected 4 1 0",
                     rd_count, bus.req, done_count);
        end
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 50 && rd_valid !== 1'b1; j++) tick();
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== 16'h0100 + 16'(i)) begin
                errors++;
                $display("FAIL rdb_pop%0d: got valid=%b data=%h expected 1 %h",
                         i, rd_valid, rd_data, 16'h0100 + 16'(i));
            end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        for (int j = 0; j < 50 && done_count == 0; j++) tick();
        tests++;
        if (rd_count !== 6 || done_count !== 1 || addr_log[5] !== 16'h0105 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdb_end: got rd=%0d done=%0d addr5=%h rd_valid=%b expected 6 1 0105 0",
                     rd_count, done_count, addr_log[5], rd_valid);
        end
        $display("[TB] read burst with backpressure finished");
    endtask

    task automatic test_write_wrap();
        int acc;
        bit ok;
        clear_logs();
        wd_valid = 1'b0;
        send_cmd(1'b1, 16'hFFFE, 8'd4, acc, ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            wd_valid = (i % 2 == 0);
            wd_data  = 16'hD000 + 16'(wd_ready_count);
            tick();
            if (done_count > 0) begin
                ok = 1'b1;
                break;
            end
        end
        wd_valid = 1'b0;
        tests++;
        if (!ok || wr_count !== 4 || wd_ready_count !== 4 || done_count !== 1) begin
            errors++;
            $display("FAIL wrw_counts: got wr=%0d wd_ready=%0d done=%0d expected 4 4 1",
                     wr_count, wd_ready_count, done_count);
        end
        tests++;
        if (addr_log[0] !== 16'hFFFE || addr_log[1] !== 16'hFFFF ||
            addr_log[2] !== 16'h0000 || addr_log[3] !== 16'h0001) begin
            errors++;
            $display("FAIL wrw_addr: got %h %h %h %h expected fffe ffff 0000 0001",
                     addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
        end
        tests++;
        if (wdata_log[0] !== 16'hD000 || wdata_log[3] !== 16'hD003) begin
            errors++;
            $display("FAIL wrw_data: got %h %h expected d000 d003", wdata_log[0], wdata_log[3]);
        end
        tests++;
        if (strobe_no_wd !== 0) begin
            errors++;
            $display("FAIL wrw_gap: got %0d strobes without wd_valid expected 0", strobe_no_wd);
        end
        $display("[TB] gapped write burst with wrap finished");
    endtask

    task automatic test_busy_hold();
        int acc;
        bit ok;
        clear_logs();
        busy_len    = 13;
        valid_delay = 7;
        rd_ready    = 1'b0;
        send_cmd(1'b0, 16'h0200, 8'd2, acc, ok);
        wait_done(100, ok);
        busy_len    = 3;
        valid_delay = 2;
        tests++;
        if (!ok || rd_count !== 2) begin
            errors++;
            $display("FAIL busy_done: got rd=%0d done=%0d expected 2 1", rd_count, done_count);
        end
        tests++;
        if (strobe_cyc[1] - strobe_cyc[0] !== 15) begin
            errors++;
            $display("FAIL busy_gap: got %0d cycles expected 15", strobe_cyc[1] - strobe_cyc[0]);
        end
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== 16'h0200 + 16'(i)) begin
                errors++;
                $display("FAIL busy_pop%0d: got valid=%b data=%h expected 1 %h",
                         i, rd_valid, rd_data, 16'h0200 + 16'(i));
            end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        tests++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_once: got rd_valid=%b expected 0", rd_valid);
        end
        $display("[TB] busy hold read finished");
    endtask

    task automatic test_len0_reset();
        int acc;
        int done_before;
        bit ok;
        // Leave one read word in the FIFO so reset has something to flush.
        clear_logs();
        rd_ready = 1'b0;
        send_cmd(1'b0, 16'h0300, 8'd1, acc, ok);
        wait_done(40, ok);
        tests++;
        if (cmd_ready !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 16'h0300) begin
            errors++;
            $display("FAIL len0_leftover: got cmd_ready=%b rd_valid=%b data=%h expected 1 1 0300",
                     cmd_ready, rd_valid, rd_data);
        end
        clear_logs();
        wd_valid = 1'b1;
        wd_data  = 16'h5A5A;
        send_cmd(1'b1, 16'h0000, 8'd0, acc, ok);
        for (int i = 0; i < 800 && wr_count < 100; i++) tick();
        done_before = done_count;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({cmd_ready, bus.req, bus.wr, bus.rd, wd_ready, rd_valid, done} !== 7'b0) begin
            errors++;
            $display("FAIL len0_reset_outputs: got %b expected 0000000",
                     {cmd_ready, bus.req, bus.wr, bus.rd, wd_ready, rd_valid, done});
        end
        tests++;
        if ({bus.addr, bus.wdata, rd_data} !== 48'h0) begin
            errors++;
            $display("FAIL len0_reset_buses: got %h expected 0", {bus.addr, bus.wdata, rd_data});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tick();
        tests++;
        if (cmd_ready !== 1'b1 || bus.req !== 1'b0 || rd_valid !== 1'b0 ||
            done_count !== done_before || done_before !== 0) begin
            errors++;
            $display("FAIL len0_after_reset: got cmd_ready=%b req=%b rd_valid=%b done=%0d expected 1 0 0 0",
                     cmd_ready, bus.req, rd_valid, done_count);
        end
        clear_logs();
        send_cmd(1'b1, 16'h0000, 8'd0, acc, ok);
        wait_done(1500, ok);
        wd_valid = 1'b0;
        tick();
        tests++;
        if (!ok || wr_count !== 256 || done_count !== 1) begin
            errors++;
            $display("FAIL len0_full: got wr=%0d done=%0d expected 256 1", wr_count, done_count);
        end
        tests++;
        if (addr_log[0] !== 16'h0000 || addr_log[255] !== 16'h00FF) begin
            errors++;
            $display("FAIL len0_addr: got %h %h expected 0000 00ff", addr_log[0], addr_log[255]);
        end
        $display("[TB] len0 burst with reset finished");
    endtask

    task automatic test_protocol();
        tests++;
        if (both_high !== 0 || strobe_busy !== 0) begin
            errors++;
            $display("FAIL protocol: got both_high=%0d strobe_busy=%0d expected 0 0",
                     both_high, strobe_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_read_backpressure();
        test_write_wrap();
        test_busy_hold();
        test_len0_reset();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
